hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Stall/flush sequencer for the 5-stage pipeline. Sits beside the IF/ID and ID/EX pipeline registers.
Detects load-use and flag-use hazards between the ID and EX stages, and applies taken-branch redirects resolved in EX. Drives the PC enable, IF/ID hold/flush and an ID/EX bubble (control bits zeroed).
Keeps saturating stall and flush performance counters.

Parameters:
- REG_W, 5, register-specifier width
- ZERO_REG, 31, register index never treated as a hazard source (XZR)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; single clock domain, all state on posedge
- reset  in  1  synchronous, active-high
- Rn_id  in  REG_W  source A of instruction in ID
- Ab_id  in  REG_W  source B of instruction in ID
- useb_id  in  1  ID instruction reads Ab (not immediate, ALUsrc=0 or store data)
- bcond_id  in  1  ID instruction is B.cond (reads flags)
- Rd_ex  in  REG_W  destination of instruction in EX
- RegWrite_ex  in  1  EX instruction writes Rd
- MemtoReg_ex  in  1  EX instruction is a load
- update_ex  in  1  EX instruction sets flags
- br_taken_ex  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; freeze whole front end
- pc_en  out  1  PC may advance
- ifid_en  out  1  IF/ID register captures
- ifid_flush  out  1  IF/ID loads NOP next edge
- idex_bubble  out  1  ID/EX loads zeroed control next edge
- stall_cnt  out  CNT_W  cycles with pc_en=0 due to hazard
- flush_cnt  out  CNT_W  redirects taken

Behaviour:
- FSM states: RUN, LDSTALL, REDIR. State is registered; outputs are combinational from state and inputs.
- Reset:
  - while reset=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
  - first edge with reset high: state←RUN, counters←0.
  - reset mid-stall aborts the stall immediately.
- load_use = MemtoReg_ex & RegWrite_ex & Rd_ex≠ZERO_REG & (Rd_ex==Rn_id | (useb_id & Rd_ex==Ab_id)).
- flag_use = bcond_id & update_ex.
- Priority, highest first: mem_busy > br_taken_ex > load_use/flag_use.
- mem_busy=1 (any state):
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
  - state holds; counters hold. The EX pipe is frozen by its own enable.
- RUN:
  - br_taken_ex: pc_en=1 (loads target), ifid_flush=1, idex_bubble=1; flush_cnt+1; next REDIR.
  - else load_use|flag_use: pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt+1; next LDSTALL.
  - else all enables 1, no flush/bubble.
- LDSTALL:
  - Lasts exactly one cycle; the hazard is now resolved by forwarding.
  - Outputs as RUN-clean; next RUN.
  - A br_taken_ex here is handled as in RUN and goes to REDIR. It cannot occur in the cycle after a bubble, but must be handled anyway.
- REDIR:
  - One cycle: the instruction now in ID is the target fetch. Treat exactly as RUN; hazards are evaluated normally.
  - Next RUN unless a new redirect or hazard fires.
  - REDIR exists only for counting and debug visibility.
- Counters saturate at all-ones and never wrap.
- A stall and a redirect in the same cycle: only the redirect is counted.
- ZERO_REG destination never stalls.
- Sources equal to Rd_ex with RegWrite_ex=0 never stall.

Decomposition:
- Package pipe_pkg: state enum {RUN, LDSTALL, REDIR}, ZERO_REG constant, REG_W.
- Sub-module sat_counter (CNT_W, enable, synchronous clear) instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
- Reset held 3 cycles, then released -> during reset pc_en=0, idex_bubble=1, ifid_flush=1; after release pc_en=1, counts 0.
- LDUR X3 in EX (Rd_ex=3, MemtoReg_ex=1, RegWrite_ex=1), Rn_id=3 -> exactly one cycle of pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1; next cycle all enables 1.
- Same load with Rd_ex=31, Rn_id=31 -> no stall. Ab_id=3 with useb_id=0 -> no stall.
- br_taken_ex=1 with load_use also true -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt unchanged; state REDIR then RUN.
- SUBS in EX (update_ex=1), B.cond in ID -> one-cycle stall. mem_busy raised during that cycle for 4 cycles -> all enables 0, state and counters frozen; the stall completes after mem_busy drops.
- Force stall_cnt to all-ones via repeated hazards (CNT_W=4 build) -> holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-sequencer state encoding and register-file constants.
package pipe_pkg;

  localparam int REG_W    = 5;
  localparam int ZERO_REG = 31;
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    REDIR   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer beside the IF/ID and ID/EX registers: load-use and flag-use
// stalls, EX-resolved branch redirects, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int ZERO_REG = pipe_pkg::ZERO_REG,
  parameter int CNT_W    = pipe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rn_id,
  input  logic [REG_W-1:0] Ab_id,
  input  logic             useb_id,
  input  logic             bcond_id,
  input  logic [REG_W-1:0] Rd_ex,
  input  logic             RegWrite_ex,
  input  logic             MemtoReg_ex,
  input  logic             update_ex,
  input  logic             br_taken_ex,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);
  import pipe_pkg::*;

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  state_t state;
  state_t state_nxt;
  logic   load_use;
  logic   flag_use;
  logic   hazard;
  logic   stall_inc;
  logic   flush_inc;

  // Handshake-free block: every output is a level valid for the current cycle only,
  // consumed by the pipeline registers at the next posedge.
  assign load_use = MemtoReg_ex && RegWrite_ex && (Rd_ex != ZERO_IDX) &&
                    ((Rd_ex == Rn_id) || (useb_id && (Rd_ex == Ab_id)));
  assign flag_use = bcond_id && update_ex;
  assign hazard   = load_use || flag_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!mem_busy) begin
      case (state)
        RUN, REDIR: begin
          if (br_taken_ex)  state_nxt = REDIR;
          else if (hazard)  state_nxt = LDSTALL;
          else              state_nxt = RUN;
        end
        // The bubble already separates producer and consumer; forwarding covers it now.
        LDSTALL: state_nxt = br_taken_ex ? REDIR : RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
    end else if (br_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (hazard && (state != LDSTALL)) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  assign state_dbg = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .en  (flush_inc),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table from RUN plus multi-cycle
// sequences; a CNT_W=4 copy shares the stimulus to exercise counter saturation.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic       clk;
  logic       reset;
  logic [4:0] Rn_id, Ab_id, Rd_ex;
  logic       useb_id, bcond_id, RegWrite_ex, MemtoReg_ex, update_ex, br_taken_ex, mem_busy;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  state_dbg;
  logic       pc_en4, ifid_en4, ifid_flush4, idex_bubble4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic [1:0] state_dbg4;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [1:0] exp_q[$];

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .Rn_id(Rn_id), .Ab_id(Ab_id), .useb_id(useb_id),
    .bcond_id(bcond_id), .Rd_ex(Rd_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .update_ex(update_ex), .br_taken_ex(br_taken_ex), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Rn_id(Rn_id), .Ab_id(Ab_id), .useb_id(useb_id),
    .bcond_id(bcond_id), .Rd_ex(Rd_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .update_ex(update_ex), .br_taken_ex(br_taken_ex), .mem_busy(mem_busy),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .state_dbg(state_dbg4)
  );

  // Clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [4:0] rn, ab, rd;
    logic       useb, bcond, rw, m2r, upd, br, busy;
    logic       pc, en, fl, bub;
    state_t     nxt;
    logic       sinc, finc;
  } vec_t;

  vec_t vecs[13];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rn, input logic [4:0] ab, input logic [4:0] rd,
                       input logic useb, input logic bcond, input logic rw, input logic m2r,
                       input logic upd, input logic br, input logic busy);
    Rn_id = rn; Ab_id = ab; Rd_ex = rd; useb_id = useb; bcond_id = bcond;
    RegWrite_ex = rw; MemtoReg_ex = m2r; update_ex = upd; br_taken_ex = br; mem_busy = busy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, L0, L0, L0, L0, L0, L0, L0);
  endtask

  task automatic ld_hazard();
    drive(5'd3, 5'd0, 5'd3, L0, L0, L1, L1, L0, L0, L0);
  endtask

  // Scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic chk_outs(input string nm, input logic pc, input logic en,
                          input logic fl, input logic bub);
    chk({nm, ".pc_en"}, 32'(pc_en), 32'(pc));
    chk({nm, ".ifid_en"}, 32'(ifid_en), 32'(en));
    chk({nm, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({nm, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, ".stall_cnt"}, stall_cnt, 32'(exp_stall));
    chk({nm, ".flush_cnt"}, flush_cnt, 32'(exp_flush));
    chk({nm, ".stall_cnt4"}, 32'(stall_cnt4), sat4(exp_stall));
    chk({nm, ".flush_cnt4"}, 32'(flush_cnt4), sat4(exp_flush));
  endtask

  task automatic chk_state(input string nm);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: expected-state queue empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".state"}, 32'(state_dbg), 32'(e));
    end
  endtask

  initial begin
    // name rn ab rd | useb bcond rw m2r upd br busy | pc en fl bub | nxt | sinc finc
    vecs[0]  = '{"idle",      5'd0,  5'd0, 5'd0,  L0, L0, L0, L0, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[1]  = '{"ld_rn",     5'd3,  5'd0, 5'd3,  L0, L0, L1, L1, L0, L0, L0, L0, L0, L0, L1, LDSTALL, L1, L0};
    vecs[2]  = '{"ld_ab",     5'd5,  5'd3, 5'd3,  L1, L0, L1, L1, L0, L0, L0, L0, L0, L0, L1, LDSTALL, L1, L0};
    vecs[3]  = '{"ab_nouse",  5'd5,  5'd3, 5'd3,  L0, L0, L1, L1, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[4]  = '{"xzr",       5'd31, 5'd0, 5'd31, L0, L0, L1, L1, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[5]  = '{"no_wr",     5'd3,  5'd3, 5'd3,  L1, L0, L0, L1, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[6]  = '{"alu_src",   5'd3,  5'd3, 5'd3,  L1, L0, L1, L0, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[7]  = '{"flag",      5'd1,  5'd2, 5'd7,  L0, L1, L0, L0, L1, L0, L0, L0, L0, L0, L1, LDSTALL, L1, L0};
    vecs[8]  = '{"bc_noupd",  5'd1,  5'd2, 5'd7,  L0, L1, L0, L0, L0, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[9]  = '{"upd_nobc",  5'd1,  5'd2, 5'd7,  L0, L0, L0, L0, L1, L0, L0, L1, L1, L0, L0, RUN,     L0, L0};
    vecs[10] = '{"br_ld",     5'd3,  5'd0, 5'd3,  L0, L0, L1, L1, L0, L1, L0, L1, L1, L1, L1, REDIR,   L0, L1};
    vecs[11] = '{"busy_ld",   5'd3,  5'd0, 5'd3,  L0, L0, L1, L1, L0, L0, L1, L0, L0, L0, L0, RUN,     L0, L0};
    vecs[12] = '{"busy_br",   5'd0,  5'd0, 5'd0,  L0, L0, L0, L0, L0, L1, L1, L0, L0, L0, L0, RUN,     L0, L0};

    // Reset held three cycles
    reset = 1'b1;
    idle();
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_outs("rst_hold", L0, L0, L1, L1);
      tick();
    end
    chk_outs("rst_last", L0, L0, L1, L1);
    reset = 1'b0;
    #1;
    chk_outs("rst_rel", L1, L1, L0, L0);
    chk_cnts("rst_rel");
    exp_q.push_back(RUN);
    chk_state("rst_rel");

    // Vector table, each applied from RUN
    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].ab, vecs[i].rd, vecs[i].useb, vecs[i].bcond,
            vecs[i].rw, vecs[i].m2r, vecs[i].upd, vecs[i].br, vecs[i].busy);
      #1;
      chk_outs(vecs[i].name, vecs[i].pc, vecs[i].en, vecs[i].fl, vecs[i].bub);
      tick();
      if (vecs[i].sinc) exp_stall++;
      if (vecs[i].finc) exp_flush++;
      exp_q.push_back(vecs[i].nxt);
      chk_state(vecs[i].name);
      chk_cnts(vecs[i].name);
      idle();
      tick();
      exp_q.push_back(RUN);
      chk_state({vecs[i].name, "_ret"});
    end

    // Load-use stall lasts exactly one cycle even with the hazard still presented
    ld_hazard();
    #1;
    chk_outs("seq_ld0", L0, L0, L0, L1);
    tick();
    exp_stall++;
    exp_q.push_back(LDSTALL);
    chk_state("seq_ld1");
    chk_outs("seq_ld1", L1, L1, L0, L0);
    tick();
    exp_q.push_back(RUN);
    chk_state("seq_ld2");
    chk_cnts("seq_ld2");
    idle();
    tick();

    // Redirect out of LDSTALL, then a hazard evaluated normally in REDIR
    ld_hazard();
    tick();
    exp_stall++;
    exp_q.push_back(LDSTALL);
    chk_state("seq_br0");
    drive(5'd3, 5'd0, 5'd3, L0, L0, L1, L1, L0, L1, L0);
    #1;
    chk_outs("seq_br_ldst", L1, L1, L1, L1);
    tick();
    exp_flush++;
    exp_q.push_back(REDIR);
    chk_state("seq_br1");
    chk_cnts("seq_br1");
    ld_hazard();
    #1;
    chk_outs("seq_redir_hz", L0, L0, L0, L1);
    tick();
    exp_stall++;
    exp_q.push_back(LDSTALL);
    chk_state("seq_br2");
    chk_cnts("seq_br2");
    idle();
    tick();
    exp_q.push_back(RUN);
    chk_state("seq_br3");

    // Flag-use stall frozen by mem_busy for four cycles
    drive(5'd1, 5'd2, 5'd7, L0, L1, L0, L0, L1, L0, L1);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_outs("seq_busy", L0, L0, L0, L0);
      tick();
      exp_q.push_back(RUN);
      chk_state("seq_busy");
      chk_cnts("seq_busy");
    end
    mem_busy = 1'b0;
    #1;
    chk_outs("seq_busy_rel", L0, L0, L0, L1);
    tick();
    exp_stall++;
    exp_q.push_back(LDSTALL);
    chk_state("seq_busy_rel");
    chk_cnts("seq_busy_rel");
    mem_busy = 1'b1;
    tick();
    exp_q.push_back(LDSTALL);
    chk_state("seq_busy_ldst");
    chk_outs("seq_busy_ldst", L0, L0, L0, L0);
    idle();
    #1;
    chk_outs("seq_ldst_clean", L1, L1, L0, L0);
    tick();
    exp_q.push_back(RUN);
    chk_state("seq_busy_end");
    chk_cnts("seq_busy_end");

    // Reset in the middle of a stall
    ld_hazard();
    tick();
    exp_stall++;
    exp_q.push_back(LDSTALL);
    chk_state("seq_rst0");
    reset = 1'b1;
    #1;
    chk_outs("seq_rst_hold", L0, L0, L1, L1);
    tick();
    reset = 1'b0;
    idle();
    #1;
    exp_stall = 0;
    exp_flush = 0;
    exp_q.push_back(RUN);
    chk_state("seq_rst1");
    chk_cnts("seq_rst1");

    // Twenty stalls: the 4-bit copy must stick at 15
    ld_hazard();
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_stall++;
      tick();
    end
    idle();
    #1;
    chk_cnts("seq_sat");
    chk("seq_sat.abs4", 32'(stall_cnt4), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
